// File: rtl/enviador_pkg.sv
// Shared definitions for the lock digit transmitter: state encoding, strobe
// polarity and BCD nibble extraction.
package enviador_pkg;

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    PREPARA   = 3'd1,
    PULSO     = 3'd2,
    INTERVALO = 3'd3,
    FIM       = 3'd4,
    ABORTA    = 3'd5
  } estado_t;

  localparam logic        INSERE_ATIVO = 1'b0;
  localparam int unsigned MAX_DIGITS   = 8;

  // Digit k of an n-digit code, k=0 being the most significant nibble.
  function automatic logic [3:0] digito(input logic [4*MAX_DIGITS-1:0] code,
                                        input int unsigned n,
                                        input int unsigned k);
    logic [4*MAX_DIGITS-1:0] desloc;
    desloc = code >> (4 * (n - 1 - k));
    return desloc[3:0];
  endfunction

  function automatic logic codigo_valido(input logic [4*MAX_DIGITS-1:0] code,
                                         input int unsigned n);
    logic ok;
    ok = 1'b1;
    for (int unsigned k = 0; k < n; k++) begin
      if (digito(code, n, k) > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/temporizador_ciclos.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module temporizador_ciclos #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             carrega,
  input  logic             habilita,
  input  logic [WIDTH-1:0] valor,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (carrega) begin
      cnt_d = valor;
    end else if (habilita && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/enviador_senha.sv
// Plays a stored BCD code into the lock as active-low insere strobes, MS digit
// first, and stops early if the lock's error LED is lit at the end of a gap.
module enviador_senha
  import enviador_pkg::*;
#(
  parameter int unsigned             N_DIGITS    = 6,
  parameter logic [4*N_DIGITS-1:0]   CODE        = 24'h590981,
  parameter int unsigned             HOLD_CYCLES = 4,
  parameter int unsigned             GAP_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inicia,
  input  logic       erro_in,
  output logic [3:0] numero,
  output logic       insere,
  output logic       ocupado,
  output logic       concluido,
  output logic       abortado,
  output logic [2:0] indice
);

  localparam int unsigned MAX_CICLOS = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned TW         = $clog2(MAX_CICLOS + 1);
  localparam logic [TW-1:0] CARGA_PULSO     = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] CARGA_INTERVALO = TW'(GAP_CYCLES - 1);
  localparam logic [4*MAX_DIGITS-1:0] CODE_EXT = (4*MAX_DIGITS)'(CODE);
  localparam logic [2:0]  ULTIMO     = 3'(N_DIGITS - 1);

  if ((N_DIGITS < 1) || (N_DIGITS > MAX_DIGITS)) begin : g_chk_digits
    $error("enviador_senha: N_DIGITS must be in 1..8");
  end
  if ((HOLD_CYCLES < 1) || (GAP_CYCLES < 1)) begin : g_chk_tempos
    $error("enviador_senha: HOLD_CYCLES and GAP_CYCLES must be >= 1");
  end
  if (!codigo_valido(CODE_EXT, N_DIGITS)) begin : g_chk_bcd
    $error("enviador_senha: CODE contains a non-BCD nibble");
  end

  estado_t    state_q, state_d;
  logic [3:0] numero_q, numero_d;
  logic       insere_q, insere_d;
  logic       ocupado_q, ocupado_d;
  logic       concluido_q, concluido_d;
  logic       abortado_q, abortado_d;
  logic [2:0] indice_q, indice_d;

  logic          tempo_zero;
  logic          tempo_carrega;
  logic          tempo_habilita;
  logic [TW-1:0] tempo_valor;

  temporizador_ciclos #(
    .WIDTH (TW)
  ) u_temporizador (
    .clk      (clk),
    .reset    (reset),
    .carrega  (tempo_carrega),
    .habilita (tempo_habilita),
    .valor    (tempo_valor),
    .zero     (tempo_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= OCIOSO;
      numero_q    <= '0;
      insere_q    <= ~INSERE_ATIVO;
      ocupado_q   <= 1'b0;
      concluido_q <= 1'b0;
      abortado_q  <= 1'b0;
      indice_q    <= '0;
    end else begin
      state_q     <= state_d;
      numero_q    <= numero_d;
      insere_q    <= insere_d;
      ocupado_q   <= ocupado_d;
      concluido_q <= concluido_d;
      abortado_q  <= abortado_d;
      indice_q    <= indice_d;
    end
  end

  // erro_in only matters on the final gap cycle; inicia only when not busy.
  always_comb begin
    state_d = state_q;
    case (state_q)
      OCIOSO, FIM, ABORTA: if (inicia) state_d = PREPARA;
      PREPARA:             state_d = PULSO;
      PULSO:               if (tempo_zero) state_d = INTERVALO;
      INTERVALO: begin
        if (tempo_zero) begin
          if (erro_in)                  state_d = ABORTA;
          else if (indice_q == ULTIMO)  state_d = FIM;
          else                          state_d = PREPARA;
        end
      end
      default:             state_d = OCIOSO;
    endcase
  end

  // Outputs are computed from the upcoming state so they can be registered
  // without adding a cycle of latency to the strobe.
  always_comb begin
    numero_d    = numero_q;
    indice_d    = indice_q;
    ocupado_d   = ocupado_q;
    concluido_d = concluido_q;
    abortado_d  = abortado_q;
    insere_d    = (state_d == PULSO) ? INSERE_ATIVO : ~INSERE_ATIVO;

    tempo_carrega  = 1'b0;
    tempo_valor    = CARGA_PULSO;
    tempo_habilita = (state_q == PULSO) || (state_q == INTERVALO);
    if (state_q == PREPARA) begin
      tempo_carrega = 1'b1;
    end else if ((state_q == PULSO) && tempo_zero) begin
      tempo_carrega = 1'b1;
      tempo_valor   = CARGA_INTERVALO;
    end

    if (state_d != state_q) begin
      case (state_d)
        PREPARA: begin
          if (state_q == INTERVALO) begin
            indice_d = indice_q + 3'd1;
            numero_d = digito(CODE_EXT, N_DIGITS, 32'(indice_q) + 32'd1);
          end else begin
            concluido_d = 1'b0;
            abortado_d  = 1'b0;
            ocupado_d   = 1'b1;
            indice_d    = '0;
            numero_d    = digito(CODE_EXT, N_DIGITS, 0);
          end
        end
        FIM: begin
          concluido_d = 1'b1;
          ocupado_d   = 1'b0;
          numero_d    = '0;
        end
        ABORTA: begin
          abortado_d = 1'b1;
          ocupado_d  = 1'b0;
          numero_d   = '0;
        end
        default: ;
      endcase
    end
  end

  assign numero    = numero_q;
  assign insere    = insere_q;
  assign ocupado   = ocupado_q;
  assign concluido = concluido_q;
  assign abortado  = abortado_q;
  assign indice    = indice_q;

endmodule

// File: tb/tb_enviador_senha.sv
// Bench for enviador_senha: a lock model drives erro_in, a scoreboard checks
// every strobe and every completion/abort against an abstract run schedule.
module tb_enviador_senha;

  localparam int N    = 6;
  localparam int HOLD = 4;
  localparam int GAP  = 4;
  localparam int PER  = 1 + HOLD + GAP;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       inicia = 1'b0;
  logic       erro_in = 1'b0;
  logic [3:0] numero;
  logic       insere, ocupado, concluido, abortado;
  logic [2:0] indice;

  logic       inicia1 = 1'b0;
  logic       erro_in1 = 1'b0;
  logic [3:0] numero1;
  logic       insere1, ocupado1, concluido1, abortado1;
  logic [2:0] indice1;

  always #5 clk = ~clk;

  enviador_senha #(
    .N_DIGITS    (6),
    .CODE        (24'h590981),
    .HOLD_CYCLES (4),
    .GAP_CYCLES  (4)
  ) u_dut (
    .clk (clk), .reset (reset), .inicia (inicia), .erro_in (erro_in),
    .numero (numero), .insere (insere), .ocupado (ocupado),
    .concluido (concluido), .abortado (abortado), .indice (indice)
  );

  enviador_senha #(
    .N_DIGITS    (1),
    .CODE        (4'h7),
    .HOLD_CYCLES (1),
    .GAP_CYCLES  (1)
  ) u_dut1 (
    .clk (clk), .reset (reset), .inicia (inicia1), .erro_in (erro_in1),
    .numero (numero1), .insere (insere1), .ocupado (ocupado1),
    .concluido (concluido1), .abortado (abortado1), .indice (indice1)
  );

  typedef struct { int digit; int idx; } strobe_t;
  typedef struct { bit abort; int idx; int lat; } fim_t;

  strobe_t exp_s[$];
  fim_t    exp_e[$];
  int      code_d[N] = '{5, 9, 0, 9, 8, 1};
  int      secret[N];
  int      total = 0;
  int      bad = 0;
  int      cyc = 0;
  int      t0 = 0;
  int      lock_pos = 0;
  bit      lock_err = 1'b0;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Lock model: compares each strobed digit with its secret, lights the LED on
  // the first wrong one; random noise on erro_in while insere is low.
  initial begin
    bit prev_ins, prev_oc;
    prev_ins = 1'b1;
    prev_oc  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset || (ocupado && !prev_oc)) begin
        lock_pos = 0;
        lock_err = 1'b0;
      end else if (insere && !prev_ins) begin
        if (lock_pos < N && int'(numero) != secret[lock_pos]) lock_err = 1'b1;
        lock_pos++;
      end
      erro_in  = lock_err | ((!insere && !reset) ? 1'($urandom_range(0, 1)) : 1'b0);
      prev_ins = insere;
      prev_oc  = ocupado;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a strobe or an end.
  initial begin
    bit      prev_ins, prev_c, prev_a;
    int      low;
    strobe_t s;
    fim_t    e;
    prev_ins = 1'b1; prev_c = 1'b0; prev_a = 1'b0; low = 0;
    s = '{digit: 0, idx: 0};
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_s.delete();
        exp_e.delete();
        prev_ins = 1'b1; prev_c = 1'b0; prev_a = 1'b0; low = 0;
        continue;
      end
      if (prev_ins && !insere) begin
        if (exp_s.size() == 0) begin
          chk("unexpected_strobe", 1, 0);
        end else begin
          s = exp_s.pop_front();
          chk("strobe_digit", int'(numero), s.digit);
          chk("strobe_indice", int'(indice), s.idx);
        end
        low = 1;
      end else if (!insere) begin
        low++;
      end
      if (!prev_ins && insere) begin
        chk("strobe_hold_len", low, HOLD);
        chk("strobe_digit_stable", int'(numero), s.digit);
        low = 0;
      end
      if ((concluido && !prev_c) || (abortado && !prev_a)) begin
        if (exp_e.size() == 0) begin
          chk("unexpected_end", 1, 0);
        end else begin
          e = exp_e.pop_front();
          chk("end_abortado", int'(abortado), int'(e.abort));
          chk("end_concluido", int'(concluido), int'(!e.abort));
          chk("end_indice", int'(indice), e.idx);
          chk("end_latency", cyc - t0, e.lat);
          chk("end_numero", int'(numero), 0);
          chk("end_ocupado", int'(ocupado), 0);
          chk("lock_digits_seen", lock_pos, e.idx + 1);
          chk("lock_error_led", int'(lock_err), int'(e.abort));
        end
      end
      prev_ins = insere;
      prev_c   = concluido;
      prev_a   = abortado;
    end
  end

  // Schedules the expected strobes/end for one run, then issues inicia.
  task automatic start_run(input int mis, input int bad_digit, output int lat);
    int last;
    for (int i = 0; i < N; i++) secret[i] = code_d[i];
    if (mis < N) secret[mis] = bad_digit;
    last = (mis < N) ? mis : N - 1;
    for (int i = 0; i <= last; i++) exp_s.push_back('{digit: code_d[i], idx: i});
    lat = (last + 1) * PER;
    exp_e.push_back('{abort: (mis < N), idx: last, lat: lat});
    @(negedge clk);
    inicia = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    inicia = 1'b0;
    @(negedge clk);
    chk("start_ocupado", int'(ocupado), 1);
    chk("start_concluido", int'(concluido), 0);
    chk("start_abortado", int'(abortado), 0);
    chk("start_indice", int'(indice), 0);
    chk("start_numero", int'(numero), code_d[0]);
    chk("start_insere", int'(insere), 1);
  endtask

  // Stray inicia pulses land on edge t0+p; p==lat hits the final gap cycle.
  task automatic do_run(input int mis, input int bad_digit, input int p1, input int p2, input int p3);
    int lat;
    start_run(mis, bad_digit, lat);
    for (int k = 2; k <= lat; k++) begin
      @(negedge clk);
      inicia = (k == p1) || (k == p2) || (k == p3);
    end
    @(negedge clk);
    inicia = 1'b0;
    repeat (3) @(negedge clk);
    chk("drain_strobes", exp_s.size(), 0);
    chk("drain_end", exp_e.size(), 0);
    chk("idle_after_run", int'(ocupado), 0);
  endtask

  initial begin
    int lat, mis, bd, p1, p2;

    repeat (2) @(negedge clk);
    chk("reset_numero", int'(numero), 0);
    chk("reset_insere", int'(insere), 1);
    chk("reset_ocupado", int'(ocupado), 0);
    chk("reset_concluido", int'(concluido), 0);
    chk("reset_abortado", int'(abortado), 0);
    chk("reset_indice", int'(indice), 0);
    chk("reset1_insere", int'(insere1), 1);
    chk("reset1_abortado", int'(abortado1), 0);
    chk("reset1_indice", int'(indice1), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    do_run(N, 0, 5, 20, N * PER);
    do_run(2, 4, 0, 0, 3 * PER);
    do_run(N, 0, 0, 0, 0);

    for (int r = 0; r < 8; r++) begin
      mis = $urandom_range(0, 9);
      bd  = (mis < N) ? (code_d[mis] + $urandom_range(1, 9)) % 10 : 0;
      lat = ((mis < N) ? mis + 1 : N) * PER;
      p1  = $urandom_range(2, lat);
      p2  = $urandom_range(2, lat);
      do_run(mis, bd, p1, p2, 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    start_run(N, 0, lat);
    @(negedge clk);
    chk("pre_reset_insere_low", int'(insere), 0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("async_reset_insere", int'(insere), 1);
    chk("async_reset_numero", int'(numero), 0);
    chk("async_reset_ocupado", int'(ocupado), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_reset_insere", int'(insere), 1);
    chk("post_reset_ocupado", int'(ocupado), 0);
    chk("post_reset_concluido", int'(concluido), 0);
    chk("post_reset_indice", int'(indice), 0);
    chk("post_reset_no_pending", exp_s.size(), 0);

    @(negedge clk);
    inicia1 = 1'b1;
    @(posedge clk);
    #1 inicia1 = 1'b0;
    @(negedge clk);
    chk("min_prepara_numero", int'(numero1), 7);
    chk("min_prepara_insere", int'(insere1), 1);
    chk("min_prepara_ocupado", int'(ocupado1), 1);
    @(negedge clk);
    chk("min_pulso_insere", int'(insere1), 0);
    chk("min_pulso_numero", int'(numero1), 7);
    @(negedge clk);
    chk("min_gap_insere", int'(insere1), 1);
    chk("min_gap_concluido", int'(concluido1), 0);
    @(negedge clk);
    chk("min_fim_concluido", int'(concluido1), 1);
    chk("min_fim_ocupado", int'(ocupado1), 0);
    chk("min_fim_numero", int'(numero1), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
